hamming_link_ctrl: RTL and testbench

//  Two-requester scheduler for the serial Hamming(7,4) strobe link through error_inject.

---
 rtl/hamming_link_ctrl_if.sv | 37 +++
 rtl/hamming_link_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hamming_link_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_link_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hamming_link_ctrl_if
// Brief    : Requester, serial link and response bundle of hamming_link_ctrl.
// Revision : 1.0
// ---------------------------------------------------------------------------
interface hamming_link_ctrl_if;
    logic [1:0] req;
    logic [3:0] data0;
    logic [3:0] data1;
    logic [1:0] ack;
    logic [1:0] err_idx;
    logic       tx_d;
    logic       tx_strobe;
    logic [1:0] tx_idx;
    logic       rx_d;
    logic       rx_strobe;
    logic       rsp_valid;
    logic       rsp_id;
    logic [3:0] rsp_data;
    logic       rsp_corrected;
    logic       rsp_timeout;
    logic       busy;

    modport master (
        output req, data0, data1, err_idx, rx_d, rx_strobe,
        input  ack, tx_d, tx_strobe, tx_idx, rsp_valid, rsp_id, rsp_data,
               rsp_corrected, rsp_timeout, busy
    );

    modport slave (
        input  req, data0, data1, err_idx, rx_d, rx_strobe,
        output ack, tx_d, tx_strobe, tx_idx, rsp_valid, rsp_id, rsp_data,
               rsp_corrected, rsp_timeout, busy
    );
endinterface
`default_nettype wire

// File: rtl/hamming_link_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hamming_link_ctrl
// Brief    : Round-robin two-requester scheduler over a serial Hamming(7,4)
//            link with SEC decode and return-path timeout.
//            Define HLC_ERRCNT_EN to add the saturating err_cnt output.
// Revision : 1.0
// ---------------------------------------------------------------------------
module hamming_link_ctrl #(
    parameter int TIMEOUT = 31,
    parameter int RR_INIT = 0
) (
    input  wire                clk,
    input  wire                rst,
    hamming_link_ctrl_if.slave bus
`ifdef HLC_ERRCNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_RECV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);
    localparam logic       c_rr_init  = 1'(RR_INIT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_rr;
    logic       r_id;
    logic [3:0] r_data;
    logic [1:0] r_idx;
    logic [2:0] r_cnt;
    logic [7:0] r_timer;
    logic [6:0] r_rx;
    logic       r_tmo;

    logic       w_grant;
    logic       w_gid;
    logic       w_rx_win;
    logic       w_sample;
    logic       w_expire;
    logic       w_last_bit;
    logic       w_done;
    logic       w_corr;
    logic [6:0] w_code;
    logic [2:0] w_syn;
    logic [3:0] w_fix;

    assign w_code = {r_data[1] ^ r_data[2] ^ r_data[3],
                     r_data[0] ^ r_data[2] ^ r_data[3],
                     r_data[0] ^ r_data[1] ^ r_data[3],
                     r_data};

    assign w_grant    = (r_state == S_IDLE) && (bus.req != 2'b00);
    assign w_gid      = (bus.req == 2'b11) ? r_rr : bus.req[1];
    assign w_rx_win   = (r_state == S_WAIT) || (r_state == S_RECV);
    assign w_sample   = w_rx_win && bus.rx_strobe;
    // A sample in the same cycle always beats the timeout.
    assign w_expire   = w_rx_win && !bus.rx_strobe && (r_timer == c_tmo_last);
    assign w_last_bit = (r_cnt == 3'd6);
    assign w_done     = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_grant) w_state_nxt = S_SEND;
            S_SEND: if (w_last_bit) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (w_sample) begin
                    w_state_nxt = S_RECV;
                end else if (w_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_RECV: begin
                if ((w_sample && w_last_bit) || w_expire) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // r_cnt indexes the transmitted bit in SEND and the next receive slot in WAIT/RECV.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr    <= c_rr_init;
            r_id    <= 1'b0;
            r_data  <= 4'h0;
            r_idx   <= 2'd0;
            r_cnt   <= 3'd0;
            r_timer <= 8'd0;
            r_rx    <= 7'd0;
            r_tmo   <= 1'b0;
        end else if (w_grant) begin
            r_rr    <= ~w_gid;
            r_id    <= w_gid;
            r_data  <= w_gid ? bus.data1 : bus.data0;
            r_idx   <= bus.err_idx;
            r_cnt   <= 3'd0;
            r_timer <= 8'd0;
            r_rx    <= 7'd0;
            r_tmo   <= 1'b0;
        end else if (r_state == S_SEND) begin
            r_cnt <= w_last_bit ? 3'd0 : r_cnt + 3'd1;
        end else if (w_sample) begin
            r_rx[r_cnt] <= bus.rx_d;
            r_cnt       <= r_cnt + 3'd1;
            r_timer     <= 8'd0;
        end else if (w_expire) begin
            r_tmo <= 1'b1;
        end else if (w_rx_win) begin
            r_timer <= r_timer + 8'd1;
        end
    end

    always_comb begin
        w_syn = {r_rx[6] ^ r_rx[1] ^ r_rx[2] ^ r_rx[3],
                 r_rx[5] ^ r_rx[0] ^ r_rx[2] ^ r_rx[3],
                 r_rx[4] ^ r_rx[0] ^ r_rx[1] ^ r_rx[3]};
        w_fix = r_rx[3:0];
        case (w_syn)
            3'b011:  w_fix[0] = ~r_rx[0];
            3'b101:  w_fix[1] = ~r_rx[1];
            3'b110:  w_fix[2] = ~r_rx[2];
            3'b111:  w_fix[3] = ~r_rx[3];
            default: w_fix = r_rx[3:0];
        endcase
    end

    assign w_corr = w_done && !r_tmo && (w_syn != 3'b000);

    assign bus.ack           = ((r_state == S_SEND) && (r_cnt == 3'd0)) ? {r_id, ~r_id} : 2'b00;
    assign bus.tx_strobe     = (r_state == S_SEND);
    assign bus.tx_d          = (r_state == S_SEND) && w_code[r_cnt];
    assign bus.tx_idx        = r_idx;
    assign bus.rsp_valid     = w_done;
    assign bus.rsp_id        = w_done && r_id;
    assign bus.rsp_data      = (w_done && !r_tmo) ? w_fix : 4'h0;
    assign bus.rsp_corrected = w_corr;
    assign bus.rsp_timeout   = w_done && r_tmo;
    assign bus.busy          = (r_state != S_IDLE);

`ifdef HLC_ERRCNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_corr && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamming_link_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_hamming_link_ctrl
// Brief    : Randomized scoreboard bench for hamming_link_ctrl acting as the
//            requesters and the serial return link.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_hamming_link_ctrl;
    localparam int TIMEOUT = 31;
    localparam int RR_INIT = 0;

    typedef struct {
        logic       id;
        logic [3:0] data;
        logic       corr;
        logic       tmo;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic m_rr   = 1'(RR_INIT);
    exp_t sb[$];
    exp_t me;

    hamming_link_ctrl_if bus();

`ifdef HLC_ERRCNT_EN
    logic [7:0] err_cnt;
    int         m_errcnt = 0;
`endif

    hamming_link_ctrl #(.TIMEOUT(TIMEOUT), .RR_INIT(RR_INIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef HLC_ERRCNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] c;
        c[3:0] = d;
        c[4]   = d[0] ^ d[1] ^ d[3];
        c[5]   = d[0] ^ d[2] ^ d[3];
        c[6]   = d[1] ^ d[2] ^ d[3];
        return c;
    endfunction

    function automatic int outs();
        return int'({bus.ack, bus.tx_d, bus.tx_strobe, bus.tx_idx, bus.rsp_valid, bus.rsp_id,
                     bus.rsp_data, bus.rsp_corrected, bus.rsp_timeout, bus.busy});
    endfunction

    // Response monitor: any rsp_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                me = sb.pop_front();
                check("rsp_id", int'(bus.rsp_id), int'(me.id));
                check("rsp_data", int'(bus.rsp_data), int'(me.data));
                check("rsp_corrected", int'(bus.rsp_corrected), int'(me.corr));
                check("rsp_timeout", int'(bus.rsp_timeout), int'(me.tmo));
                check("rsp_cycle", cyc, me.cyc);
                check("busy_at_rsp", int'(bus.busy), 1);
`ifdef HLC_ERRCNT_EN
                if (me.corr && m_errcnt < 255) m_errcnt++;
`endif
            end
        end
    end

    // mode 0: full return, 1: no return, 2: three bits then silence.
    task automatic frame(input logic [1:0] reqv, input logic [3:0] d0, input logic [3:0] d1,
                         input logic [1:0] eidx, input int mode, input int flip, input int gap,
                         input bit hold, input bit abort);
        logic       win;
        logic [3:0] dw;
        logic [6:0] cw;
        logic [6:0] got;
        int         n;
        int         strobes;
        int         acks;
        int         busy_low;
        int         nbits;
        int         a;
        exp_t       e;

        bus.req     = reqv;
        bus.data0   = d0;
        bus.data1   = d1;
        bus.err_idx = eidx;
        win = (reqv == 2'b11) ? m_rr : reqv[1];
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack == 2'b00 && n < 8);
        check("grant_latency", n, 1);
        if (bus.ack == 2'b00) begin
            bus.req = 2'b00;
            return;
        end
        check("ack_onehot", int'(bus.ack), win ? 2 : 1);
        check("tx_idx", int'(bus.tx_idx), int'(eidx));
        m_rr  = ~win;
        dw    = win ? d1 : d0;
        cw    = encode(dw);
        a     = cyc;
        nbits = (mode == 0) ? 7 : ((mode == 2) ? 3 : 0);
        if (!abort) begin
            e.id   = win;
            e.tmo  = (mode != 0);
            e.data = e.tmo ? 4'h0 : dw;
            e.corr = !e.tmo && (flip >= 0);
            e.cyc  = e.tmo ? a + 7 + TIMEOUT + ((mode == 2) ? 2 * (gap + 1) + 1 : 0)
                           : a + 7 + 6 * (gap + 1) + 1;
            sb.push_back(e);
        end
        if (!hold) bus.req = 2'b00;

        strobes  = 0;
        acks     = 0;
        busy_low = 0;
        got      = '0;
        for (int k = 0; k < 7; k++) begin
            if (bus.tx_strobe) begin
                got[k] = bus.tx_d;
                strobes++;
            end
            if (bus.ack != 2'b00) acks++;
            if (!bus.busy) busy_low++;
            bus.rx_strobe = 1'($urandom_range(0, 1));
            bus.rx_d      = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        if (bus.tx_strobe) strobes++;
        if (bus.ack != 2'b00) acks++;
        check("tx_strobe_cycles", strobes, 7);
        check("tx_codeword", int'(got), int'(cw));
        check("ack_pulse_cycles", acks, 1);
        check("tx_idx_held", int'(bus.tx_idx), int'(eidx));

        bus.rx_strobe = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            bus.rx_strobe = 1'b1;
            bus.rx_d      = cw[i] ^ (i == flip);
            if (abort && i == 4) begin
                rst = 1'b1;
                @(negedge clk);
                check("rst_abort_outputs", outs(), 0);
                rst           = 1'b0;
                bus.rx_strobe = 1'b0;
                m_rr          = 1'(RR_INIT);
`ifdef HLC_ERRCNT_EN
                m_errcnt = 0;
`endif
                return;
            end
            @(negedge clk);
            if (!bus.busy) busy_low++;
            if (i < nbits - 1) begin
                for (int g = 0; g < gap; g++) begin
                    bus.rx_strobe = 1'b0;
                    bus.rx_d      = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (!bus.busy) busy_low++;
                end
            end
        end
        bus.rx_strobe = 1'b0;

        n = 0;
        while (bus.busy && n < TIMEOUT + 60) begin
            @(negedge clk);
            n++;
        end
        check("frame_completes", int'(bus.busy), 0);
        check("busy_mid_frame", busy_low, 0);
    endtask

    initial begin
        int r;
        int mode;
        rst           = 1'b1;
        bus.req       = 2'b00;
        bus.data0     = 4'h0;
        bus.data1     = 4'h0;
        bus.err_idx   = 2'd0;
        bus.rx_d      = 1'b0;
        bus.rx_strobe = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs", outs(), 0);

        // Abort mid-RECV, then both requesting must start again from RR_INIT.
        frame(2'b11, 4'h5, 4'h9, 2'd3, 0, -1, 0, 1'b0, 1'b1);
        for (int f = 0; f < 4; f++)
            frame(2'b11, 4'($urandom), 4'($urandom), 2'($urandom), 0, -1, 0, 1'b1, 1'b0);
        bus.req = 2'b00;

        frame(2'b01, 4'hA, 4'h3, 2'd0, 0, 0, 0, 1'b0, 1'b0);

        for (int v = 0; v < 16; v++)
            frame((v % 2 == 0) ? 2'b01 : 2'b10, 4'(v), 4'(v), 2'($urandom), 0, -1, 0, 1'b0, 1'b0);

        frame(2'b10, 4'h6, 4'hC, 2'd2, 1, -1, 0, 1'b0, 1'b0);
        frame(2'b01, 4'h7, 4'h1, 2'd1, 0, 5, 3, 1'b0, 1'b0);
        frame(2'b11, 4'hE, 4'h2, 2'd0, 2, -1, 1, 1'b0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            r    = int'($urandom_range(0, 9));
            mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            frame(2'($urandom_range(1, 3)), 4'($urandom), 4'($urandom), 2'($urandom), mode,
                  int'($urandom_range(0, 7)) - 1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
`ifdef HLC_ERRCNT_EN
        check("err_cnt", int'(err_cnt), m_errcnt);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
